// File: rtl/pipe_reg_elastic_if.sv
// ============================================================================
// pipe_reg_elastic_if
// Handshake bundle for one pipeline stage boundary: upstream (D) side with
// valid/ready/data/ctrl, downstream (E) side likewise, plus the stall count.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipe_reg_elastic_if #(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 16
);
    logic              valid_d;
    logic              ready_d;
    logic [DATA_W-1:0] data_d;
    logic [CTRL_W-1:0] ctrl_d;
    logic              valid_e;
    logic              ready_e;
    logic [DATA_W-1:0] data_e;
    logic [CTRL_W-1:0] ctrl_e;
    logic [CNT_W-1:0]  stall_cnt_e;

    // Environment side: produces upstream items and downstream ready.
    modport master (
        output valid_d, data_d, ctrl_d, ready_e,
        input  ready_d, valid_e, data_e, ctrl_e, stall_cnt_e
    );

    // Register side: consumes upstream items and presents the head entry.
    modport slave (
        input  valid_d, data_d, ctrl_d, ready_e,
        output ready_d, valid_e, data_e, ctrl_e, stall_cnt_e
    );
endinterface

`default_nettype wire

// File: rtl/pipe_reg_elastic.sv
// ============================================================================
// pipe_reg_elastic
// Elastic pipeline register with a two-entry skid buffer (main + skid),
// registered upstream ready, flush with control-bubble insertion and an
// optional saturating stall-cycle counter enabled by PIPE_STALL_CNT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_reg_elastic #(
    parameter int DATA_W    = 96,
    parameter int CTRL_W    = 16,
    parameter bit ZERO_DATA = 1'b1,
    parameter int CNT_W     = 16
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          clr,
    pipe_reg_elastic_if.slave  bus
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,   // main invalid
        S_BUSY  = 2'd1,   // main valid, skid empty
        S_FULL  = 2'd2    // main and skid valid
    } state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] main_data, main_data_nxt;
    logic [CTRL_W-1:0] main_ctrl, main_ctrl_nxt;
    logic [DATA_W-1:0] skid_data, skid_data_nxt;
    logic [CTRL_W-1:0] skid_ctrl, skid_ctrl_nxt;
    logic              ready_q;
    logic              main_valid;
    logic              acc;
    logic              rel;

    // Valid flags are implied by the state: main is valid outside EMPTY,
    // skid is valid only in FULL (which is also what drops ready).
    assign main_valid = (state != S_EMPTY);
    assign acc        = bus.valid_d & ready_q;
    assign rel        = main_valid & bus.ready_e;

    // Next-state and entry-load decisions; flush overrides any handshake.
    always_comb begin
        state_nxt     = state;
        main_data_nxt = main_data;
        main_ctrl_nxt = main_ctrl;
        skid_data_nxt = skid_data;
        skid_ctrl_nxt = skid_ctrl;
        if (clr) begin
            // An item accepted this cycle is discarded; one released this
            // cycle has already been delivered downstream.
            state_nxt     = S_EMPTY;
            main_ctrl_nxt = '0;
            skid_ctrl_nxt = '0;
            if (ZERO_DATA) begin
                main_data_nxt = '0;
                skid_data_nxt = '0;
            end
        end else begin
            case (state)
                S_EMPTY: begin
                    if (acc) begin
                        state_nxt     = S_BUSY;
                        main_data_nxt = bus.data_d;
                        main_ctrl_nxt = bus.ctrl_d;
                    end
                end
                S_BUSY: begin
                    if (acc && rel) begin
                        main_data_nxt = bus.data_d;
                        main_ctrl_nxt = bus.ctrl_d;
                    end else if (acc) begin
                        state_nxt     = S_FULL;
                        skid_data_nxt = bus.data_d;
                        skid_ctrl_nxt = bus.ctrl_d;
                    end else if (rel) begin
                        state_nxt     = S_EMPTY;
                    end
                end
                S_FULL: begin
                    // ready is low here, so no accept can coincide.
                    if (rel) begin
                        state_nxt     = S_BUSY;
                        main_data_nxt = skid_data;
                        main_ctrl_nxt = skid_ctrl;
                        skid_ctrl_nxt = '0;
                    end
                end
                default: begin
                    state_nxt = S_EMPTY;
                end
            endcase
        end
    end

    // State and entry registers; ready is registered from the next state so
    // it never depends combinationally on downstream ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_EMPTY;
            main_data <= '0;
            main_ctrl <= '0;
            skid_data <= '0;
            skid_ctrl <= '0;
            ready_q   <= 1'b0;
        end else begin
            state     <= state_nxt;
            main_data <= main_data_nxt;
            main_ctrl <= main_ctrl_nxt;
            skid_data <= skid_data_nxt;
            skid_ctrl <= skid_ctrl_nxt;
            ready_q   <= (state_nxt != S_FULL);
        end
    end

    assign bus.ready_d = ready_q;
    assign bus.valid_e = main_valid;
    assign bus.data_e  = main_data;
    // Bubbles carry zero control so they can never commit side effects.
    assign bus.ctrl_e  = main_ctrl & {CTRL_W{main_valid}};

`ifdef PIPE_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt;

    // Saturating count of cycles the head item is held by downstream;
    // only reset clears it, flush leaves it alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (main_valid && !bus.ready_e && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign bus.stall_cnt_e = stall_cnt;
`else
    assign bus.stall_cnt_e = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_reg_elastic.sv
// ============================================================================
// tb_pipe_reg_elastic
// Self-checking bench: directed scenarios plus randomized traffic compared
// against a queue-based model of a two-deep FIFO with registered ready.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_reg_elastic;

    localparam int DATA_W    = 96;
    localparam int CTRL_W    = 16;
    localparam bit ZERO_DATA = 1'b1;
    localparam int CNT_W     = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
`ifdef PIPE_STALL_CNT_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    typedef struct {
        logic [DATA_W-1:0] d;
        logic [CTRL_W-1:0] c;
    } item_t;

    logic clk = 1'b0;
    logic rst;
    logic clr;

    pipe_reg_elastic_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) bus_if ();

    pipe_reg_elastic #(
        .DATA_W(DATA_W), .CTRL_W(CTRL_W), .ZERO_DATA(ZERO_DATA), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .clr(clr),
        .bus(bus_if.slave)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    item_t             q[$];
    bit                m_ready = 1'b0;
    logic [DATA_W-1:0] m_data  = '0;
    logic [CNT_W-1:0]  m_cnt   = '0;

    function automatic logic [CTRL_W-1:0] ctl_of(input logic [DATA_W-1:0] d);
        return d[CTRL_W-1:0] | 16'h8000;
    endfunction

    // Drive one cycle of inputs, advance through the edge, update the model,
    // and return at the following negedge where outputs are stable.
    task automatic tick(input bit v, input logic [DATA_W-1:0] d, input bit re,
                        input bit cl, input bit rs);
        item_t it;
        bit    acc;
        bit    rel;
        bus_if.valid_d = v;
        bus_if.data_d  = d;
        bus_if.ctrl_d  = ctl_of(d);
        bus_if.ready_e = re;
        clr            = cl;
        rst            = rs;
        @(posedge clk);
        if (rs) begin
            q.delete();
            m_ready = 1'b0;
            m_cnt   = '0;
            m_data  = '0;
        end else begin
            acc = v && m_ready;
            rel = (q.size() > 0) && re;
            if (STALL_EN && (q.size() > 0) && !re && (m_cnt != CNT_MAX))
                m_cnt = m_cnt + 1'b1;
            if (cl) begin
                q.delete();
                if (ZERO_DATA) m_data = '0;
            end else begin
                if (rel) void'(q.pop_front());
                if (acc) begin
                    it.d = d;
                    it.c = ctl_of(d);
                    q.push_back(it);
                end
            end
            m_ready = (q.size() < 2);
            if (q.size() > 0) m_data = q[0].d;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        tick(1'b0, '0, 1'b0, 1'b0, 1'b1);
        tick(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        // Reset with flush and a valid offer: everything zero, ready low.
        tick(1'b1, 96'h77, 1'b1, 1'b1, 1'b1);
        tick(1'b1, 96'h78, 1'b0, 1'b1, 1'b1);
        checks++; if (bus_if.valid_e !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", bus_if.valid_e); end
        checks++; if (bus_if.data_e !== '0) begin errors++; $display("FAIL rst_data: got %h want 0", bus_if.data_e); end
        checks++; if (bus_if.ctrl_e !== '0) begin errors++; $display("FAIL rst_ctrl: got %h want 0", bus_if.ctrl_e); end
        checks++; if (bus_if.ready_d !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", bus_if.ready_d); end
        checks++; if (bus_if.stall_cnt_e !== '0) begin errors++; $display("FAIL rst_cnt: got %0d want 0", bus_if.stall_cnt_e); end
        // First edge after reset raises ready; offers here are not accepted.
        tick(1'b1, 96'h79, 1'b0, 1'b0, 1'b0);
        checks++; if (bus_if.ready_d !== 1'b1) begin errors++; $display("FAIL rst_ready_rise: got %b want 1", bus_if.ready_d); end
        checks++; if (bus_if.valid_e !== 1'b0) begin errors++; $display("FAIL rst_no_accept: got %b want 0", bus_if.valid_e); end
        tick(1'b1, 96'h55, 1'b0, 1'b0, 1'b0);
        checks++; if (bus_if.valid_e !== 1'b1 || bus_if.data_e !== 96'h55) begin
            errors++; $display("FAIL rst_first_accept: got v=%b d=%h want v=1 d=55", bus_if.valid_e, bus_if.data_e); end
    endtask

    task automatic test_streaming();
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            tick(1'b1, DATA_W'(k), 1'b1, 1'b0, 1'b0);
            checks++; if (bus_if.valid_e !== 1'b1 || bus_if.data_e !== DATA_W'(k) || bus_if.ctrl_e !== ctl_of(DATA_W'(k))) begin
                errors++; $display("FAIL stream_item%0d: got v=%b d=%h c=%h want v=1 d=%0d", k, bus_if.valid_e, bus_if.data_e, bus_if.ctrl_e, k); end
            checks++; if (bus_if.ready_d !== 1'b1) begin errors++; $display("FAIL stream_ready%0d: got %b want 1", k, bus_if.ready_d); end
        end
        tick(1'b0, '0, 1'b1, 1'b0, 1'b0);
        checks++; if (bus_if.valid_e !== 1'b0 || bus_if.ctrl_e !== '0) begin
            errors++; $display("FAIL stream_drain: got v=%b c=%h want v=0 c=0", bus_if.valid_e, bus_if.ctrl_e); end
    endtask

    task automatic test_stall();
        do_reset();
        tick(1'b1, 96'hA, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 96'hB, 1'b0, 1'b0, 1'b0);
        checks++; if (bus_if.ready_d !== 1'b0 || bus_if.data_e !== 96'hA) begin
            errors++; $display("FAIL stall_full: got rdy=%b d=%h want rdy=0 d=a", bus_if.ready_d, bus_if.data_e); end
        tick(1'b1, 96'hC, 1'b0, 1'b0, 1'b0);
        checks++; if (bus_if.ready_d !== 1'b0 || bus_if.data_e !== 96'hA) begin
            errors++; $display("FAIL stall_hold: got rdy=%b d=%h want rdy=0 d=a", bus_if.ready_d, bus_if.data_e); end
        tick(1'b1, 96'hC, 1'b1, 1'b0, 1'b0);
        checks++; if (bus_if.ready_d !== 1'b1 || bus_if.data_e !== 96'hB || bus_if.valid_e !== 1'b1) begin
            errors++; $display("FAIL stall_recover: got rdy=%b d=%h want rdy=1 d=b", bus_if.ready_d, bus_if.data_e); end
        tick(1'b1, 96'hC, 1'b1, 1'b0, 1'b0);
        checks++; if (bus_if.data_e !== 96'hC || bus_if.valid_e !== 1'b1) begin
            errors++; $display("FAIL stall_third: got v=%b d=%h want v=1 d=c", bus_if.valid_e, bus_if.data_e); end
        tick(1'b0, '0, 1'b1, 1'b0, 1'b0);
        checks++; if (bus_if.valid_e !== 1'b0) begin errors++; $display("FAIL stall_drain: got %b want 0", bus_if.valid_e); end
    endtask

    task automatic test_flush();
        do_reset();
        tick(1'b1, 96'hA, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 96'hB, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 96'hC, 1'b0, 1'b1, 1'b0);
        checks++; if (bus_if.valid_e !== 1'b0 || bus_if.ctrl_e !== '0 || bus_if.ready_d !== 1'b1) begin
            errors++; $display("FAIL flush_state: got v=%b c=%h rdy=%b want v=0 c=0 rdy=1", bus_if.valid_e, bus_if.ctrl_e, bus_if.ready_d); end
        checks++; if (bus_if.data_e !== '0) begin errors++; $display("FAIL flush_data: got %h want 0", bus_if.data_e); end
        for (int k = 0; k < 3; k++) begin
            tick(1'b0, '0, 1'b1, 1'b0, 1'b0);
            checks++; if (bus_if.valid_e !== 1'b0) begin
                errors++; $display("FAIL flush_leak%0d: got v=%b d=%h want v=0", k, bus_if.valid_e, bus_if.data_e); end
        end
    endtask

    task automatic test_stall_counter();
        logic [CNT_W-1:0] exp;
        do_reset();
        tick(1'b1, 96'h5, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            tick(1'b0, '0, 1'b0, 1'b0, 1'b0);
            if (k == 10 || k == 20) begin
                exp = STALL_EN ? ((k > 15) ? CNT_MAX : CNT_W'(k)) : '0;
                checks++; if (bus_if.stall_cnt_e !== exp || bus_if.valid_e !== 1'b1) begin
                    errors++; $display("FAIL cnt_after%0d: got cnt=%0d v=%b want cnt=%0d v=1", k, bus_if.stall_cnt_e, bus_if.valid_e, exp); end
            end
        end
        tick(1'b0, '0, 1'b0, 1'b1, 1'b0);
        exp = STALL_EN ? CNT_MAX : '0;
        checks++; if (bus_if.stall_cnt_e !== exp) begin
            errors++; $display("FAIL cnt_clr: got %0d want %0d", bus_if.stall_cnt_e, exp); end
        tick(1'b0, '0, 1'b0, 1'b0, 1'b1);
        checks++; if (bus_if.stall_cnt_e !== '0) begin
            errors++; $display("FAIL cnt_rst: got %0d want 0", bus_if.stall_cnt_e); end
    endtask

    task automatic test_random();
        logic [CTRL_W-1:0] exp_c;
        int                bad;
        do_reset();
        bad = 0;
        for (int n = 0; n < 500; n++) begin
            tick(($urandom_range(0, 99) < 70), {$urandom, $urandom, $urandom},
                 ($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 3),
                 ($urandom_range(0, 199) < 1));
            exp_c = (q.size() > 0) ? q[0].c : '0;
            checks++;
            if (bus_if.valid_e !== (q.size() > 0) || bus_if.data_e !== m_data ||
                bus_if.ctrl_e !== exp_c || bus_if.ready_d !== m_ready ||
                bus_if.stall_cnt_e !== m_cnt) begin
                errors++;
                bad++;
                if (bad <= 5)
                    $display("FAIL rand_cyc%0d: got v=%b d=%h c=%h rdy=%b cnt=%0d want v=%b d=%h c=%h rdy=%b cnt=%0d",
                             n, bus_if.valid_e, bus_if.data_e, bus_if.ctrl_e, bus_if.ready_d, bus_if.stall_cnt_e,
                             (q.size() > 0), m_data, exp_c, m_ready, m_cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_stall();
        test_flush();
        test_stall_counter();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
